// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: command-side controller for the 16-bit registered ALU.
// Takes one command at a time over a valid/ready channel, drives the ALU,
// collects its flags and registered result, and returns them over a
// valid/ready response channel. A divide with B == 0 is answered locally
// so the ALU never sees that case.
module alu_cmd_ctrl #(
   parameter logic [15:0] DIV0_VALUE = 16'hFFFF,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [3:0]       CMD_FUN,
   input  logic [15:0]      CMD_A,
   input  logic [15:0]      CMD_B,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [15:0]      RSP_DATA,
   output logic [4:0]       RSP_FLAGS,
   output logic             RSP_ERR,
   output logic [CNT_W-1:0] CMD_COUNT,
   output logic [15:0]      ALU_A,
   output logic [15:0]      ALU_B,
   output logic [3:0]       ALU_FUN,
   input  logic [15:0]      ALU_OUT,
   input  logic             Arith_Flag,
   input  logic             Carry_Flag,
   input  logic             Logic_Flag,
   input  logic             CMP_Flag,
   input  logic             Shift_Flag
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_RESP
   } state_t;

   localparam logic [3:0] FUN_IDLE = 4'b1111;
   localparam logic [3:0] FUN_DIV  = 4'b0011;

   state_t             r_state;
   logic [15:0]        r_alu_a;
   logic [15:0]        r_alu_b;
   logic [3:0]         r_alu_fun;
   logic               r_rsp_valid;
   logic [15:0]        r_rsp_data;
   logic [4:0]         r_rsp_flags;
   logic               r_rsp_err;
   logic [CNT_W-1:0]   r_cmd_count;

   logic               w_div0;
   logic [4:0]         w_flags;

   assign w_div0  = (CMD_FUN == FUN_DIV) && (CMD_B == 16'h0000);
   assign w_flags = {Arith_Flag, Carry_Flag, Logic_Flag, CMP_Flag, Shift_Flag};

   // Command sequencing: accept, issue to ALU, capture result, hold response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_fun   <= FUN_IDLE;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_flags <= '0;
         r_rsp_err   <= 1'b0;
         r_cmd_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (CMD_VALID) begin
                  r_alu_a <= CMD_A;
                  r_alu_b <= CMD_B;
                  if (w_div0) begin
                     // ALU function select stays idle: the trap is answered here
                     r_rsp_data  <= DIV0_VALUE;
                     r_rsp_flags <= '0;
                     r_rsp_err   <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end else begin
                     r_alu_fun <= CMD_FUN;
                     r_rsp_err <= 1'b0;
                     r_state   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // Flags are combinational from the now-stable ALU inputs;
               // the ALU registers its result on this same edge.
               r_rsp_flags <= w_flags;
               r_state     <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_rsp_data  <= ALU_OUT;
               r_alu_fun   <= FUN_IDLE;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (RSP_READY) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_count <= r_cmd_count + 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Ready is withheld combinationally while reset is asserted
   always_comb begin
      CMD_READY = (r_state == S_IDLE) && !rst;
   end

   assign ALU_A     = r_alu_a;
   assign ALU_B     = r_alu_b;
   assign ALU_FUN   = r_alu_fun;
   assign RSP_VALID = r_rsp_valid;
   assign RSP_DATA  = r_rsp_data;
   assign RSP_FLAGS = r_rsp_flags;
   assign RSP_ERR   = r_rsp_err;
   assign CMD_COUNT = r_cmd_count;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: self-checking bench for alu_cmd_ctrl with a stand-in
// registered ALU and a transaction-level reference model.
module tb_alu_cmd_ctrl;

   localparam int unsigned CNT_W = 8;
   localparam logic [15:0] DIV0  = 16'hFFFF;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             CMD_READY;
   logic [3:0]       cmd_fun;
   logic [15:0]      cmd_a;
   logic [15:0]      cmd_b;
   logic             RSP_VALID;
   logic             rsp_ready;
   logic [15:0]      RSP_DATA;
   logic [4:0]       RSP_FLAGS;
   logic             RSP_ERR;
   logic [CNT_W-1:0] CMD_COUNT;
   logic [15:0]      ALU_A;
   logic [15:0]      ALU_B;
   logic [3:0]       ALU_FUN;
   logic [15:0]      alu_out;
   logic             f_arith, f_carry, f_logic, f_cmp, f_shift;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc   = 0;

   always #5 clk = ~clk;

   alu_cmd_ctrl #(.DIV0_VALUE(DIV0), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .CMD_VALID(cmd_valid), .CMD_READY(CMD_READY), .CMD_FUN(cmd_fun),
      .CMD_A(cmd_a), .CMD_B(cmd_b),
      .RSP_VALID(RSP_VALID), .RSP_READY(rsp_ready), .RSP_DATA(RSP_DATA),
      .RSP_FLAGS(RSP_FLAGS), .RSP_ERR(RSP_ERR), .CMD_COUNT(CMD_COUNT),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_OUT(alu_out),
      .Arith_Flag(f_arith), .Carry_Flag(f_carry), .Logic_Flag(f_logic),
      .CMP_Flag(f_cmp), .Shift_Flag(f_shift)
   );

   // Reference ALU behaviour: 17-bit result so the carry is visible
   function automatic logic [16:0] ref_full(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] r;
      r = '0;
      case (f)
         4'h0: r = {1'b0, a} + {1'b0, b};
         4'h1: r = {1'b0, a} - {1'b0, b};
         4'h2: r = {1'b0, 16'(a * b)};
         4'h3: r = (b == 16'h0) ? 17'd0 : {1'b0, 16'(a / b)};
         4'h4: r = {1'b0, a & b};
         4'h5: r = {1'b0, a | b};
         4'h6: r = {1'b0, ~(a & b)};
         4'h7: r = {1'b0, ~(a | b)};
         4'h8: r = {1'b0, a ^ b};
         4'h9: r = {1'b0, ~(a ^ b)};
         4'hA: r = (a == b) ? 17'd1 : 17'd0;
         4'hB: r = (a > b)  ? 17'd2 : 17'd0;
         4'hC: r = (a < b)  ? 17'd3 : 17'd0;
         4'hD: r = {1'b0, a >> 1};
         4'hE: r = {1'b0, a << 1};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] ref_res(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] r;
      r = ref_full(f, a, b);
      return r[15:0];
   endfunction

   // {Arith, Carry, Logic, CMP, Shift}
   function automatic logic [4:0] ref_flags(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] r;
      logic        ar, ca, lg, cm, sh;
      r  = ref_full(f, a, b);
      ar = (f <= 4'h3);
      ca = (f <= 4'h1) && r[16];
      lg = (f >= 4'h4) && (f <= 4'h9);
      cm = (f >= 4'hA) && (f <= 4'hC);
      sh = (f == 4'hD) || (f == 4'hE);
      return {ar, ca, lg, cm, sh};
   endfunction

   // Stand-in ALU: combinational flags, one-cycle registered result
   assign {f_arith, f_carry, f_logic, f_cmp, f_shift} = ref_flags(ALU_FUN, ALU_A, ALU_B);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) alu_out <= '0;
      else     alu_out <= ref_res(ALU_FUN, ALU_A, ALU_B);
   end

   // Transaction-level model: one outstanding command, response after a latency
   bit               m_busy, m_valid;
   int unsigned      m_wait;
   logic [15:0]      m_data, m_a, m_b, p_data;
   logic [4:0]       m_flags, p_flags;
   logic             m_err;
   logic [3:0]       m_fun;
   logic [CNT_W-1:0] m_count;

   task automatic model_reset();
      m_busy = 0; m_valid = 0; m_wait = 0;
      m_data = '0; m_a = '0; m_b = '0; p_data = '0;
      m_flags = '0; p_flags = '0; m_err = 1'b0; m_fun = 4'hF; m_count = '0;
   endtask

   task automatic model_step();
      if (m_valid) begin
         if (rsp_ready) begin
            m_valid = 0; m_busy = 0; m_count = m_count + 1'b1;
         end
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_busy = 1; m_a = cmd_a; m_b = cmd_b;
            if (cmd_fun == 4'h3 && cmd_b == 16'h0) begin
               m_data = DIV0; m_flags = '0; m_err = 1'b1; m_valid = 1;
            end else begin
               m_fun = cmd_fun; m_wait = 2;
               p_data = ref_res(cmd_fun, cmd_a, cmd_b);
               p_flags = ref_flags(cmd_fun, cmd_a, cmd_b);
            end
         end
      end else begin
         m_wait = m_wait - 1;
         if (m_wait == 0) begin
            m_valid = 1; m_data = p_data; m_flags = p_flags; m_err = 1'b0; m_fun = 4'hF;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic check_all();
      chk("CMD_READY", 32'(CMD_READY), 32'(!m_busy));
      chk("RSP_VALID", 32'(RSP_VALID), 32'(m_valid));
      chk("CMD_COUNT", 32'(CMD_COUNT), 32'(m_count));
      chk("ALU_FUN",   32'(ALU_FUN),   32'(m_fun));
      chk("ALU_A",     32'(ALU_A),     32'(m_a));
      chk("ALU_B",     32'(ALU_B),     32'(m_b));
      chk("NO_DIV0_AT_ALU", 32'(ALU_FUN == 4'h3 && ALU_B == 16'h0), 32'(0));
      if (m_valid) begin
         chk("RSP_DATA",  32'(RSP_DATA),  32'(m_data));
         chk("RSP_FLAGS", 32'(RSP_FLAGS), 32'(m_flags));
         chk("RSP_ERR",   32'(RSP_ERR),   32'(m_err));
      end
   endtask

   // One clock: model advances on the edge, outputs compared half a cycle later
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      check_all();
   endtask

   // One command from idle; returns the response and edges from accept to RSP_VALID
   task automatic do_cmd(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input int unsigned hold, output logic [15:0] d, output logic [4:0] fl,
                         output logic e, output int unsigned lat, output bit nonf);
      nonf = 0;
      cmd_valid = 1'b1; cmd_fun = f; cmd_a = a; cmd_b = b; rsp_ready = 1'b0;
      cycle();
      cmd_valid = 1'b0;
      lat = 1;
      if (ALU_FUN != 4'hF) nonf = 1;
      while (!RSP_VALID && lat < 8) begin
         cycle();
         lat++;
         if (ALU_FUN != 4'hF) nonf = 1;
      end
      d = RSP_DATA; fl = RSP_FLAGS; e = RSP_ERR;
      for (int unsigned i = 0; i < hold; i++) begin
         cmd_valid = 1'b1; cmd_fun = 4'h0;
         cmd_a = 16'($urandom); cmd_b = 16'($urandom);
         cycle();
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [15:0]      d;
      logic [4:0]       fl;
      logic             e;
      int unsigned      lat;
      bit               nonf;
      logic [CNT_W-1:0] c0;
      int unsigned      rises, last_rise, hs, guard;
      bit               prev_v, seen_wrap, spacing_ok;
      logic [CNT_W-1:0] prev_cnt;

      rst = 1'b1; cmd_valid = 1'b0; cmd_fun = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      chk("RST_CMD_READY", 32'(CMD_READY), 32'(0));
      chk("RST_RSP_VALID", 32'(RSP_VALID), 32'(0));
      chk("RST_ALU_FUN",   32'(ALU_FUN),   32'(4'hF));
      chk("RST_RSP_DATA",  32'(RSP_DATA),  32'(0));
      chk("RST_FLAGS_ERR", 32'({RSP_FLAGS, RSP_ERR}), 32'(0));
      chk("RST_COUNT",     32'(CMD_COUNT), 32'(0));
      chk("RST_ALU_AB",    32'({ALU_A, ALU_B}), 32'(0));
      rst = 1'b0;
      cycle();

      // ADD with carry out
      do_cmd(4'h0, 16'hFFFF, 16'h0001, 0, d, fl, e, lat, nonf);
      chk("ADD_DATA",  32'(d),   32'h0);
      chk("ADD_FLAGS", 32'(fl),  32'(5'b11000));
      chk("ADD_ERR",   32'(e),   32'(0));
      chk("ADD_LAT",   32'(lat), 32'd3);

      // Divide by zero trapped locally
      do_cmd(4'h3, 16'h0010, 16'h0000, 0, d, fl, e, lat, nonf);
      chk("DIV0_DATA",   32'(d),    32'hFFFF);
      chk("DIV0_FLAGS",  32'(fl),   32'(0));
      chk("DIV0_ERR",    32'(e),    32'(1));
      chk("DIV0_LAT",    32'(lat),  32'd1);
      chk("DIV0_ALUFUN", 32'(nonf), 32'(0));

      // Idle opcode as a command
      do_cmd(4'hF, 16'h1234, 16'h5678, 0, d, fl, e, lat, nonf);
      chk("NOP_RSP", 32'({d, fl, e}), 32'(0));

      // Backpressure on GT with competing commands
      c0 = m_count;
      do_cmd(4'hB, 16'h0005, 16'h0003, 5, d, fl, e, lat, nonf);
      chk("GT_DATA",  32'(d),  32'h2);
      chk("GT_FLAGS", 32'(fl), 32'(5'b00010));
      chk("BP_COUNT", 32'(CMD_COUNT), 32'(CNT_W'(c0 + 1'b1)));

      // Back-to-back SUB with both valids held high
      cmd_valid = 1'b1; rsp_ready = 1'b1; cmd_fun = 4'h1; cmd_a = 16'h0003; cmd_b = 16'h0005;
      rises = 0; last_rise = 0; prev_v = 0; spacing_ok = 1; guard = 0;
      while (rises < 5 && guard < 40) begin
         cycle(); guard++;
         if (RSP_VALID && !prev_v) begin
            if (rises == 0) begin
               chk("SUB_DATA",  32'(RSP_DATA),     32'hFFFE);
               chk("SUB_CARRY", 32'(RSP_FLAGS[3]), 32'(1));
            end else if (cyc - last_rise != 4) spacing_ok = 0;
            last_rise = cyc; rises++;
         end
         prev_v = RSP_VALID;
      end
      chk("B2B_RESPONSES", 32'(rises), 32'd5);
      chk("B2B_SPACING",   32'(spacing_ok), 32'(1));
      cmd_valid = 1'b0;
      repeat (5) cycle();

      // Counter wrap over 256 AND commands
      c0 = m_count; hs = 0; guard = 0; seen_wrap = 0; prev_cnt = CMD_COUNT;
      cmd_valid = 1'b1; rsp_ready = 1'b1; cmd_fun = 4'h4;
      while (hs < 256 && guard < 1200) begin
         cmd_a = 16'($urandom); cmd_b = 16'($urandom);
         if (RSP_VALID) hs++;
         if (hs == 256) cmd_valid = 1'b0;
         cycle(); guard++;
         if (prev_cnt == '1 && CMD_COUNT == '0) seen_wrap = 1;
         prev_cnt = CMD_COUNT;
      end
      cmd_valid = 1'b0;
      cycle();
      chk("WRAP_SEEN",  32'(seen_wrap), 32'(1));
      chk("WRAP_COUNT", 32'(CMD_COUNT), 32'(c0));

      // Reset during CAPTURE
      cmd_valid = 1'b1; cmd_fun = 4'h0; cmd_a = 16'h0001; cmd_b = 16'h0002; rsp_ready = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      cycle();
      rst = 1'b1;
      model_reset();
      #1;
      chk("MIDRST_VALID",   32'(RSP_VALID), 32'(0));
      chk("MIDRST_COUNT",   32'(CMD_COUNT), 32'(0));
      chk("MIDRST_ALU_FUN", 32'(ALU_FUN),   32'(4'hF));
      chk("MIDRST_READY",   32'(CMD_READY), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (4) cycle();
      chk("POSTRST_READY", 32'(CMD_READY), 32'(1));

      // Randomized traffic
      for (int unsigned i = 0; i < 1500; i++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         rsp_ready = ($urandom_range(0, 2) != 0);
         cmd_fun   = 4'($urandom);
         cmd_a     = 16'($urandom);
         cmd_b     = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         if ($urandom_range(0, 5) == 0) cmd_fun = 4'h3;
         cycle();
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      repeat (6) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side controller for the 16-bit registered ALU. It accepts one operation at a time over a valid/ready command channel and drives the operands and function code onto the ALU. It samples the ALU's combinational flags and its one-cycle-registered result, then returns both over a valid/ready response channel. It sits between a bus/sequencer master and the ALU instance, and guards the divide-by-zero case so the ALU never sees it.

## Interface
- DIV0_VALUE, 16'hFFFF, result returned for divide with B == 0
- CNT_W, 8, width of completed-command counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  controller can accept a command
- CMD_FUN  in  4  ALU function code
- CMD_A, CMD_B  in  16 each  operands
- RSP_VALID  out  1  response held
- RSP_READY  in  1  master accepts response
- RSP_DATA  out  16  result
- RSP_FLAGS  out  5  {Arith, Carry, Logic, CMP, Shift}
- RSP_ERR  out  1  divide-by-zero trapped
- CMD_COUNT  out  CNT_W  completed responses, wraps
- ALU_A, ALU_B  out  16 each  to ALU A, B
- ALU_FUN  out  4  to ALU function select
- ALU_OUT  in  16  ALU registered result
- Arith_Flag, Carry_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  ALU combinational flags

## Operation
- FSM states are IDLE, ISSUE, CAPTURE, RESP. Exactly one command is outstanding at a time.
- CMD_READY = (state == IDLE) and not rst. It is 0 in every other state. CMD_VALID outside IDLE is ignored.
- IDLE, on CMD_VALID:
  - Register CMD_A and CMD_B into ALU_A and ALU_B.
  - If CMD_FUN == 4'b0011 and CMD_B == 0: ALU_FUN stays 4'b1111, RSP_DATA = DIV0_VALUE, RSP_FLAGS = 0, RSP_ERR = 1, next state RESP.
  - Otherwise: ALU_FUN = CMD_FUN, RSP_ERR = 0, next state ISSUE.
- ISSUE: ALU inputs are stable. At the end of the cycle, capture the five flag inputs into RSP_FLAGS. The ALU registers its result on the same edge. Next state CAPTURE.
- CAPTURE: capture ALU_OUT into RSP_DATA, set ALU_FUN back to 4'b1111, next state RESP.
- RESP: RSP_VALID = 1. RSP_DATA, RSP_FLAGS and RSP_ERR are held stable until RSP_READY is sampled high. On that handshake, CMD_COUNT increments (modulo 2^CNT_W) and the next state is IDLE.
- ALU_FUN is 4'b1111 whenever no operation is in flight. The ALU then outputs 0 with no flags.
- Opcode 4'b1111 issued as a command runs the normal path and returns 0 with flags 0 and RSP_ERR = 0.
- All results are passed through unmodified. The controller performs no arithmetic except the B == 0 check.

## Timing
- Accept edge = rising edge with CMD_VALID && CMD_READY.
- Normal path: RSP_VALID is high after the 3rd rising edge following the accept edge (accept edge, ISSUE edge, CAPTURE edge).
- Divide-by-zero path: RSP_VALID is high immediately after the accept edge.
- Response handshake edge: RSP_VALID drops and CMD_READY rises after that edge. The earliest next accept is the following edge.
- Throughput: 1 command per 4 cycles (normal path) or 2 cycles (div0 path).
- Reset values: state IDLE; ALU_A = ALU_B = 0; ALU_FUN = 4'b1111; RSP_VALID = 0; RSP_DATA = 0; RSP_FLAGS = 0; RSP_ERR = 0; CMD_COUNT = 0; CMD_READY = 0 while rst is high.
- Reset mid-operation, any state: in-flight command is discarded, no response is produced, and all outputs return to reset values immediately (async).
- CMD_COUNT wraps from all-ones to 0 with no sticky indication.

## Test plan
- ADD: A = 0xFFFF, B = 0x0001, FUN 0000 -> RSP_DATA 0x0000, RSP_FLAGS 5'b11000, RSP_ERR 0, RSP_VALID exactly 3 edges after accept.
- DIV by zero: A = 0x0010, B = 0x0000, FUN 0011 -> RSP_DATA 0xFFFF, RSP_FLAGS 0, RSP_ERR 1, RSP_VALID 1 edge after accept, ALU_FUN never leaves 4'b1111.
- Backpressure: GT, A = 0x0005, B = 0x0003, FUN 1011, RSP_READY low for 5 cycles -> RSP_DATA 0x0002 and RSP_FLAGS 5'b00010 held stable, CMD_READY 0, a competing CMD_VALID is not accepted, CMD_COUNT increments only on release.
- Back-to-back SUB: CMD_VALID and RSP_READY held high, A = 0x0003, B = 0x0005, FUN 0001 -> RSP_DATA 0xFFFE, Carry 1, one response every 4 cycles.
- Counter wrap: 256 consecutive AND commands -> CMD_COUNT steps 0xFF -> 0x00.
- Reset mid-op: assert rst during CAPTURE -> RSP_VALID 0, CMD_COUNT 0, ALU_FUN 4'b1111 at once; after release no response appears and CMD_READY is 1.
